tdm_demux4: RTL and testbench
=============================

# tdm_demux4

Receive-side deframer for the 4-slot time-division bit stream produced by the team's 4:1 mux, which selects `i0`..`i3` onto one line `y` using a 2-bit slot select. This block sits at the far end of that line. It tracks the slot sequence from a frame-sync marker and routes each bit into one of four per-channel shift registers. After WIDTH frames it presents four parallel channel words with a one-cycle valid pulse. It flags and recovers from sync loss.

## Interface
- `WIDTH`, default 8: bits per channel word, equal to the number of frames per word; legal range 2..32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `din` input 1: serial TDM data, the far-end mux output.
- `din_en` input 1: bit strobe; `din`/`fsync` are sampled only when high.
- `fsync` input 1: high together with the slot-0 bit of every frame.
- `slot` output 2: slot index the next strobed bit will be assigned to. Encoding {sel1,sel2}: 0→ch0, 1→ch1, 2→ch2, 3→ch3.
- `ch0`, `ch1`, `ch2`, `ch3` output WIDTH: last completed channel words, MSB first as received.
- `valid` output 1: one-cycle pulse when `ch0`..`ch3` update.
- `locked` output 1: high while in LOCKED.
- `sync_err` output 1: one-cycle pulse on a framing violation.

## Operation
- Reset values:
  - `slot`=0, `ch0`..`ch3`=0, `valid`=0, `locked`=0, `sync_err`=0.
  - Shift registers=0, frame counter=0, state=HUNT.
- States: HUNT, LOCKED.
- HUNT:
  - Strobes with `fsync`=0 are discarded.
  - A strobe with `fsync`=1 takes that bit as slot 0 of frame 0, sets `slot`=1, and moves to LOCKED.
- LOCKED: each strobe shifts `din` into shift register[`slot`] (shift left, new bit at LSB), then `slot` increments mod 4.
- Frame counter: increments when a slot-3 bit is taken. When the slot-3 bit of frame WIDTH-1 is taken:
  - copy all four shift registers into `ch0`..`ch3`;
  - assert `valid`;
  - clear the frame counter.
- Framing violations in LOCKED, each causing a `sync_err` pulse:
  - `fsync`=1 with `slot`≠0: resync.
    - Discard the partial word (clear shift registers and frame counter).
    - Take this bit as slot 0 of frame 0, set `slot`=1, stay LOCKED.
  - `fsync`=0 with `slot`=0: lose lock.
    - Discard the partial word and the bit.
    - Go to HUNT with `slot`=0.
- `ch0`..`ch3` hold their last value until the next completed word; a sync error never changes them.
- `din_en`=0 freezes all state; there is no timeout.
- `rst_n` low mid-word: immediate return to reset values; the partial word is lost, and nothing is output.

## Timing
- Synchronous design apart from reset; reset deassertion must be synchronised upstream.
- All outputs registered.
- `valid` and new `ch*` values appear on the edge that samples the final bit, and are visible the cycle after that strobe. `valid` lasts exactly one cycle even when `din_en` is held high.
- `sync_err` is asserted in the cycle after the offending strobe.
- `locked` rises with the first accepted `fsync` and falls in the cycle after loss of lock.
- Maximum throughput: one bit per clock (`din_en` tied high); one word set every 4×WIDTH clocks.

## Structure
- Shared package/include `tdm_pkg`:
  - `TDM_SLOTS`=4, `TDM_SLOT_W`=2;
  - state encodings `ST_HUNT`=1'b0, `ST_LOCKED`=1'b1.
  - The transmit-side mux controller uses the same package.
- Natural sub-module `tdm_chan_shift`: WIDTH-bit shift register with shift-enable and synchronous clear. Instantiated four times; the top level holds the FSM, slot counter and frame counter.

## Test plan
- WIDTH=8, `din_en`=1, `fsync` on every slot 0, channel words 0xA5, 0x3C, 0xFF, 0x00 interleaved over 32 bits → one `valid` pulse one cycle after bit 32, with `ch0`=A5, `ch1`=3C, `ch2`=FF, `ch3`=00.
- Same traffic, `din_en` toggling every other clock → identical words, with `valid` one clock after the final strobe.
- 3 junk bits with `fsync`=0 before the first sync → ignored, `locked` stays 0, and the first word decodes correctly.
- `fsync` asserted at `slot`=2 in frame 5 → `sync_err` pulse, `slot`=1, `ch*` unchanged. A complete word (0x12, 0x34, 0x56, 0x78) sent with that bit taken as slot 0 then decodes correctly.
- `fsync` missing at slot 0 → `sync_err`, `locked`=0, and the next `fsync` relocks.
- `rst_n` pulsed low after 20 bits → all outputs 0 immediately, state HUNT, and no `valid` until a full new word is received.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-slot TDM link (transmit mux controller and
// receive deframer). No ports; provides slot constants, the deframer state
// encoding and a slot-advance helper.
package tdm_pkg;

    localparam int TDM_SLOTS  = 4;
    localparam int TDM_SLOT_W = 2;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } tdm_state_e;

    // Next slot index; wraps 3 -> 0 through the natural 2-bit overflow.
    function automatic logic [TDM_SLOT_W-1:0] tdm_slot_next(input logic [TDM_SLOT_W-1:0] cur);
        return cur + 2'd1;
    endfunction

endpackage

// File: rtl/tdm_chan_shift.sv
// Per-channel receive shift register for the TDM deframer.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   shift_en_i   - shift din_i in at the LSB (MSB-first word assembly)
//   clr_i        - synchronous clear; together with shift_en_i the register
//                  restarts holding only the new bit
//   din_i        - serial data bit
//   q_o          - current register contents
module tdm_chan_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en_i,
    input  logic             clr_i,
    input  logic             din_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sr_q;

    // Shift register with clear; clear+shift restarts a word from this bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= {WIDTH{1'b0}};
        end else if (clr_i && shift_en_i) begin
            sr_q <= {{(WIDTH-1){1'b0}}, din_i};
        end else if (clr_i) begin
            sr_q <= {WIDTH{1'b0}};
        end else if (shift_en_i) begin
            sr_q <= {sr_q[WIDTH-2:0], din_i};
        end else begin
            sr_q <= sr_q;
        end
    end

    assign q_o = sr_q;

endmodule

// File: rtl/tdm_demux4.sv
// Receive-side deframer for the 4-slot TDM bit stream. Locks on fsync,
// steers each strobed bit into one of four channel shift registers and,
// after WIDTH frames, presents four parallel words with a valid pulse.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   din, din_en     - serial data and its sampling strobe
//   fsync           - high with the slot-0 bit of each frame
//   slot            - slot the next strobed bit will go to
//   ch0..ch3        - last completed channel words (MSB first as received)
//   valid           - one-cycle pulse when ch0..ch3 update
//   locked          - high while frame alignment is held
//   sync_err        - one-cycle pulse on a framing violation
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_en,
    input  logic             fsync,
    output logic [1:0]       slot,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic             valid,
    output logic             locked,
    output logic             sync_err
);

    localparam int FW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(WIDTH - 1);

    tdm_state_e             state_q;
    logic [TDM_SLOT_W-1:0]  slot_q;
    logic [FW-1:0]          frame_q;
    logic [WIDTH-1:0]       ch0_q, ch1_q, ch2_q, ch3_q;
    logic                   valid_q;
    logic                   sync_err_q;

    logic [TDM_SLOTS-1:0]   shift_en_s;
    logic                   clr_s;
    logic [WIDTH-1:0]       sr0_s, sr1_s, sr2_s, sr3_s;

    // Shift-register steering: which channel takes the bit, and when the
    // partial word is discarded (sync start, resync or loss of lock).
    always_comb begin
        shift_en_s = {TDM_SLOTS{1'b0}};
        clr_s      = 1'b0;
        if (din_en) begin
            case (state_q)
                ST_HUNT: begin
                    if (fsync) begin
                        clr_s         = 1'b1;
                        shift_en_s[0] = 1'b1;
                    end else begin
                        clr_s = 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (fsync && (slot_q != 2'd0)) begin
                        clr_s         = 1'b1;
                        shift_en_s[0] = 1'b1;
                    end else if (!fsync && (slot_q == 2'd0)) begin
                        clr_s = 1'b1;
                    end else begin
                        shift_en_s[slot_q] = 1'b1;
                    end
                end
                default: begin
                    clr_s = 1'b1;
                end
            endcase
        end else begin
            clr_s = 1'b0;
        end
    end

    tdm_chan_shift #(.WIDTH(WIDTH)) u_sr0 (
        .clk(clk), .rst_n(rst_n), .shift_en_i(shift_en_s[0]), .clr_i(clr_s), .din_i(din), .q_o(sr0_s)
    );
    tdm_chan_shift #(.WIDTH(WIDTH)) u_sr1 (
        .clk(clk), .rst_n(rst_n), .shift_en_i(shift_en_s[1]), .clr_i(clr_s), .din_i(din), .q_o(sr1_s)
    );
    tdm_chan_shift #(.WIDTH(WIDTH)) u_sr2 (
        .clk(clk), .rst_n(rst_n), .shift_en_i(shift_en_s[2]), .clr_i(clr_s), .din_i(din), .q_o(sr2_s)
    );
    tdm_chan_shift #(.WIDTH(WIDTH)) u_sr3 (
        .clk(clk), .rst_n(rst_n), .shift_en_i(shift_en_s[3]), .clr_i(clr_s), .din_i(din), .q_o(sr3_s)
    );

    // Framing FSM, slot/frame counters and registered word outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HUNT;
            slot_q     <= 2'd0;
            frame_q    <= {FW{1'b0}};
            ch0_q      <= {WIDTH{1'b0}};
            ch1_q      <= {WIDTH{1'b0}};
            ch2_q      <= {WIDTH{1'b0}};
            ch3_q      <= {WIDTH{1'b0}};
            valid_q    <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            valid_q    <= 1'b0;
            sync_err_q <= 1'b0;
            if (din_en) begin
                case (state_q)
                    ST_HUNT: begin
                        if (fsync) begin
                            state_q <= ST_LOCKED;
                            slot_q  <= 2'd1;
                            frame_q <= {FW{1'b0}};
                        end else begin
                            slot_q  <= 2'd0;
                        end
                    end
                    ST_LOCKED: begin
                        if (fsync && (slot_q != 2'd0)) begin
                            // Early marker: restart alignment on this bit.
                            sync_err_q <= 1'b1;
                            slot_q     <= 2'd1;
                            frame_q    <= {FW{1'b0}};
                        end else if (!fsync && (slot_q == 2'd0)) begin
                            // Missing marker: alignment is no longer trusted.
                            sync_err_q <= 1'b1;
                            state_q    <= ST_HUNT;
                            slot_q     <= 2'd0;
                            frame_q    <= {FW{1'b0}};
                        end else begin
                            slot_q <= tdm_slot_next(slot_q);
                            if (slot_q == 2'd3) begin
                                if (frame_q == FRAME_LAST) begin
                                    // ch3 is still being shifted this edge, so
                                    // capture it with the incoming bit appended.
                                    ch0_q   <= sr0_s;
                                    ch1_q   <= sr1_s;
                                    ch2_q   <= sr2_s;
                                    ch3_q   <= {sr3_s[WIDTH-2:0], din};
                                    valid_q <= 1'b1;
                                    frame_q <= {FW{1'b0}};
                                end else begin
                                    frame_q <= frame_q + FW'(1);
                                end
                            end else begin
                                frame_q <= frame_q;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_HUNT;
                        slot_q  <= 2'd0;
                        frame_q <= {FW{1'b0}};
                    end
                endcase
            end else begin
                state_q <= state_q;
            end
        end
    end

    assign slot     = slot_q;
    assign ch0      = ch0_q;
    assign ch1      = ch1_q;
    assign ch2      = ch2_q;
    assign ch3      = ch3_q;
    assign valid    = valid_q;
    assign locked   = (state_q == ST_LOCKED);
    assign sync_err = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4 (WIDTH=8). Expected words are queued
// when the final bit of a word is driven and compared when valid fires.
module tb_tdm_demux4;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             din;
    logic             din_en;
    logic             fsync;
    logic [1:0]       slot;
    logic [WIDTH-1:0] ch0, ch1, ch2, ch3;
    logic             valid;
    logic             locked;
    logic             sync_err;

    typedef struct packed {
        logic [31:0] w;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    tdm_demux4 #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_en(din_en), .fsync(fsync),
        .slot(slot), .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
        .valid(valid), .locked(locked), .sync_err(sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: every valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("valid_unexpected", 32'(valid), 32'd0);
            end else begin
                e_mon = sb.pop_front();
                check("ch0", 32'(ch0), 32'(e_mon.w[31:24]));
                check("ch1", 32'(ch1), 32'(e_mon.w[23:16]));
                check("ch2", 32'(ch2), 32'(e_mon.w[15:8]));
                check("ch3", 32'(ch3), 32'(e_mon.w[7:0]));
                check("valid_cycle", 32'(cyc), 32'(e_mon.at));
            end
        end
    end

    task automatic send_bit(input logic b, input logic fs);
        @(negedge clk);
        din    = b;
        fsync  = fs;
        din_en = 1'b1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        din_en = 1'b0;
        din    = 1'($urandom);
        fsync  = 1'($urandom);
    endtask

    // Step to the cycle after the last strobe and stop strobing.
    task automatic after_strobe();
        @(negedge clk);
        din_en = 1'b0;
        fsync  = 1'b0;
    endtask

    // Bits first..last (0..31) of a word set; bit i is frame i/4, slot i%4.
    task automatic send_word(input logic [31:0] ww, input int first, input int last, input bit tog);
        logic [7:0] cw;
        int f, s;
        for (int i = first; i <= last; i++) begin
            if (tog && (i != first)) idle_cycle();
            f  = i / 4;
            s  = i % 4;
            cw = ww[(3-s)*8 +: 8];
            send_bit(cw[7-f], (s == 0));
            if (i == 31) sb.push_back('{w: ww, at: cyc + 1});
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_slot"},     32'(slot),     32'd0);
        check({tag, "_ch0"},      32'(ch0),      32'd0);
        check({tag, "_ch1"},      32'(ch1),      32'd0);
        check({tag, "_ch2"},      32'(ch2),      32'd0);
        check({tag, "_ch3"},      32'(ch3),      32'd0);
        check({tag, "_valid"},    32'(valid),    32'd0);
        check({tag, "_locked"},   32'(locked),   32'd0);
        check({tag, "_sync_err"}, 32'(sync_err), 32'd0);
    endtask

    task automatic check_ch(input string tag, input logic [31:0] ww);
        check({tag, "_ch"}, {ch0, ch1, ch2, ch3}, ww);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        din    = 1'b0;
        din_en = 1'b0;
        fsync  = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Continuous strobes, then same traffic with din_en toggling.
        send_word(32'hA53CFF00, 0, 31, 1'b0);
        send_word(32'hA53CFF00, 0, 31, 1'b1);
        after_strobe();
        check("locked_after_words", 32'(locked), 32'd1);
        check("slot_after_words",   32'(slot),   32'd0);

        // Reset, then junk bits without fsync must be ignored.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) send_bit(1'($urandom), 1'b0);
        after_strobe();
        check("junk_locked",   32'(locked),   32'd0);
        check("junk_slot",     32'(slot),     32'd0);
        check("junk_sync_err", 32'(sync_err), 32'd0);
        send_word(32'hA53CFF00, 0, 31, 1'b0);

        // Early fsync at frame 5 slot 2 restarts the word on that bit.
        send_word(32'h99C3663C, 0, 21, 1'b0);
        send_word(32'h12345678, 0, 0, 1'b0);
        after_strobe();
        check("resync_err",    32'(sync_err), 32'd1);
        check("resync_slot",   32'(slot),     32'd1);
        check("resync_locked", 32'(locked),   32'd1);
        check_ch("resync", 32'hA53CFF00);
        @(negedge clk);
        check("resync_err_pulse", 32'(sync_err), 32'd0);
        send_word(32'h12345678, 1, 31, 1'b0);

        // Missing fsync at slot 0 drops lock; next fsync relocks.
        send_word(32'h55AA33CC, 0, 7, 1'b0);
        send_bit(1'b1, 1'b0);
        after_strobe();
        check("loss_err",    32'(sync_err), 32'd1);
        check("loss_locked", 32'(locked),   32'd0);
        check("loss_slot",   32'(slot),     32'd0);
        check_ch("loss", 32'h12345678);
        @(negedge clk);
        check("loss_err_pulse", 32'(sync_err), 32'd0);
        send_word(32'hDEADBEEF, 0, 31, 1'b0);

        // Reset mid-word: outputs clear at once and the partial word is lost.
        send_word(32'h11223344, 0, 19, 1'b0);
        @(negedge clk);
        din_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_outputs_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        send_word(32'h0FF0817E, 0, 31, 1'b0);
        after_strobe();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
